// File: rtl/rle_loader.sv
// Byte-stream snapshot loader: copies raw bytes or expands ESC,count,value runs
// into memory starting at BASE, with a write-accept handshake and start-up hold.
module rle_loader #(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   BASE     = 'h2000,
    parameter logic [7:0]      ESC      = 8'hED,
    parameter int              CW       = 8,
    parameter int              HOLD_CYC = 3000000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          start,
    input  logic          rle_en,
    input  logic          done,
    input  logic          in_wr,
    input  logic [7:0]    in_data,
    output logic          in_wait,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_data,
    output logic          mem_wr,
    input  logic          mem_ready,
    output logic          busy,
    output logic          hold_reset,
    output logic          end_seen,
    output logic          overflow
);
    localparam int HW = $clog2(HOLD_CYC + 1);

    typedef enum logic [2:0] {IDLE, HOLD, LIT, CNT, VAL, RUN, STOP} state_t;

    state_t        state, nxt;
    logic          mode;
    logic          wrapped;
    logic [HW-1:0] hold_cnt;
    logic [CW-1:0] run_cnt;
    logic          take, wr_acc, at_top, is_esc;
    logic          run_step, run_last, run_more;

    assign wr_acc   = mem_wr & mem_ready;
    assign at_top   = (mem_addr == {AW{1'b1}});
    assign is_esc   = mode & (in_data == ESC);
    assign take     = in_wr & ~in_wait & ~done & ~start & (state inside {LIT, CNT, VAL, STOP});
    // Once wrapped, a run keeps stepping with mem_wr low: each step is a dropped write.
    assign run_step = (state == RUN) & (wr_acc | ~mem_wr);
    assign run_last = (run_cnt == CW'(1));
    assign run_more = (state == RUN) & ~done & ~run_last & ~at_top;

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (start) begin
            nxt = HOLD;
        end else if (done && state != IDLE) begin
            nxt = IDLE;
        end else begin
            case (state)
                HOLD: if (hold_cnt <= HW'(1)) nxt = LIT;
                LIT:  if (take && is_esc) nxt = CNT;
                CNT:  if (take) nxt = (in_data == 8'h00) ? STOP : VAL;
                VAL:  if (take) nxt = RUN;
                RUN:  if (run_step && run_last) nxt = LIT;
                default: nxt = state;
            endcase
        end
    end

    always_comb begin
        in_wait    = mem_wr | (state == HOLD) | (state == RUN);
        hold_reset = (state == HOLD);
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mem_addr <= BASE;
            mem_data <= '0;
            mem_wr   <= 1'b0;
            busy     <= 1'b0;
            end_seen <= 1'b0;
            overflow <= 1'b0;
            wrapped  <= 1'b0;
            mode     <= 1'b0;
            hold_cnt <= '0;
            run_cnt  <= '0;
        end else if (start) begin
            mem_addr <= BASE;
            mem_wr   <= 1'b0;
            busy     <= 1'b1;
            end_seen <= 1'b0;
            overflow <= 1'b0;
            wrapped  <= 1'b0;
            mode     <= rle_en;
            hold_cnt <= HW'(HOLD_CYC);
        end else begin
            if (done) busy <= 1'b0;
            // A pending write always completes, even after done has sent us to IDLE.
            if (wr_acc) begin
                mem_addr <= mem_addr + AW'(1);
                mem_wr   <= run_more;
                if (at_top) wrapped <= 1'b1;
            end
            if (state == HOLD) hold_cnt <= hold_cnt - HW'(1);
            if (run_step && !done) begin
                run_cnt <= run_cnt - CW'(1);
                if (!mem_wr) overflow <= 1'b1;
            end
            if (take) begin
                case (state)
                    LIT: if (!is_esc) begin
                        if (wrapped) begin
                            overflow <= 1'b1;
                        end else begin
                            mem_wr   <= 1'b1;
                            mem_data <= in_data;
                        end
                    end
                    CNT: begin
                        if (in_data == 8'h00) end_seen <= 1'b1;
                        else                  run_cnt  <= CW'(in_data);
                    end
                    VAL: begin
                        mem_data <= in_data;
                        mem_wr   <= ~wrapped;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rle_loader.sv
// Directed bench for rle_loader: two instances (BASE 2000 and BASE FFFE) share stimulus.
module tb_rle_loader;
    logic        clk = 1'b0;
    logic        reset, start, rle_en, done, in_wr, mem_ready;
    logic [7:0]  in_data;
    logic        in_wait_a, mem_wr_a, busy_a, hold_a, end_a, ovf_a;
    logic [15:0] addr_a;
    logic [7:0]  data_a;
    logic        in_wait_b, mem_wr_b, busy_b, hold_b, end_b, ovf_b;
    logic [15:0] addr_b;
    logic [7:0]  data_b;
    int          tests = 0;
    int          fails = 0;

    logic [15:0] la [0:63];
    logic [7:0]  lda[0:63];
    int          wa = 0;
    logic [15:0] lb [0:63];
    logic [7:0]  ldb[0:63];
    int          wb = 0;
    int          w0;
    bit          frz;

    always #5 clk = ~clk;

    rle_loader #(.AW(16), .BASE(16'h2000), .ESC(8'hED), .CW(8), .HOLD_CYC(4)) dut_a (
        .clk_sys(clk), .reset(reset), .start(start), .rle_en(rle_en), .done(done),
        .in_wr(in_wr), .in_data(in_data), .in_wait(in_wait_a), .mem_addr(addr_a),
        .mem_data(data_a), .mem_wr(mem_wr_a), .mem_ready(mem_ready), .busy(busy_a),
        .hold_reset(hold_a), .end_seen(end_a), .overflow(ovf_a));

    rle_loader #(.AW(16), .BASE(16'hFFFE), .ESC(8'hED), .CW(8), .HOLD_CYC(4)) dut_b (
        .clk_sys(clk), .reset(reset), .start(start), .rle_en(rle_en), .done(done),
        .in_wr(in_wr), .in_data(in_data), .in_wait(in_wait_b), .mem_addr(addr_b),
        .mem_data(data_b), .mem_wr(mem_wr_b), .mem_ready(mem_ready), .busy(busy_b),
        .hold_reset(hold_b), .end_seen(end_b), .overflow(ovf_b));

    always @(posedge clk) begin
        if (!reset && !start && mem_wr_a && mem_ready && wa < 64) begin
            la[wa]  <= addr_a;
            lda[wa] <= data_a;
            wa      <= wa + 1;
        end
        if (!reset && !start && mem_wr_b && mem_ready && wb < 64) begin
            lb[wb]  <= addr_b;
            ldb[wb] <= data_b;
            wb      <= wb + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit sel);
        int n = 0;
        while ((sel ? in_wait_b : in_wait_a) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_wait still high for byte %0h", b);
        end
        in_wr = 1'b1;
        in_data = b;
        tick();
        in_wr = 1'b0;
    endtask

    task automatic begin_load(input bit rle);
        rle_en = rle;
        start = 1'b1;
        tick();
        start = 1'b0;
        rle_en = 1'b0;
    endtask

    task automatic wait_hold();
        int n = 0;
        while (hold_a && n < 20) begin
            tick();
            n++;
        end
        chk("hold_ends", 32'(hold_a), 32'h0);
    endtask

    task automatic finish_load();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; rle_en = 1'b0; done = 1'b0;
        in_wr = 1'b0; in_data = 8'h00; mem_ready = 1'b1;
        tick(); tick();
        chk("rst_addr", 32'(addr_a), 32'h2000);
        chk("rst_outs", 32'({mem_wr_a, busy_a, in_wait_a, hold_a, end_a, ovf_a}), 32'h0);
        reset = 1'b0;
        tick();

        // raw copy with 4-cycle hold
        begin_load(1'b0);
        chk("t1_busy", 32'(busy_a), 32'h1);
        n = 0;
        while (hold_a && n < 20) begin n++; tick(); end
        chk("t1_hold_len", 32'(n), 32'd4);
        w0 = wa;
        send(8'h11, 1'b0);
        chk("t1_wr_latency", 32'({mem_wr_a, in_wait_a, addr_a, data_a}), 32'({2'b11, 16'h2000, 8'h11}));
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        tick(); tick();
        chk("t1_count", 32'(wa - w0), 32'd3);
        chk("t1_w0", 32'({la[w0], lda[w0]}), 32'h200011);
        chk("t1_w1", 32'({la[w0+1], lda[w0+1]}), 32'h200122);
        chk("t1_w2", 32'({la[w0+2], lda[w0+2]}), 32'h200233);
        finish_load();
        chk("t1_busy_off", 32'(busy_a), 32'h0);

        // RLE literal + run
        begin_load(1'b1);
        wait_hold();
        w0 = wa;
        send(8'h41, 1'b0);
        send(8'hED, 1'b0);
        send(8'h03, 1'b0);
        send(8'h7F, 1'b0);
        chk("t2_run_first", 32'({mem_wr_a, addr_a, data_a}), 32'({1'b1, 16'h2001, 8'h7F}));
        frz = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!in_wait_a) frz = 1'b0;
            tick();
        end
        chk("t2_wait_in_run", 32'(frz), 32'h1);
        chk("t2_wait_release", 32'(in_wait_a), 32'h0);
        send(8'h42, 1'b0);
        tick(); tick();
        chk("t2_count", 32'(wa - w0), 32'd5);
        chk("t2_lit", 32'({la[w0], lda[w0]}), 32'h200041);
        chk("t2_run0", 32'({la[w0+1], lda[w0+1]}), 32'h20017F);
        chk("t2_run2", 32'({la[w0+3], lda[w0+3]}), 32'h20037F);
        chk("t2_tail", 32'({la[w0+4], lda[w0+4]}), 32'h200442);
        finish_load();

        // end marker
        begin_load(1'b1);
        wait_hold();
        w0 = wa;
        send(8'h55, 1'b0);
        send(8'hED, 1'b0);
        chk("t3_end_before", 32'(end_a), 32'h0);
        send(8'h00, 1'b0);
        chk("t3_end_set", 32'(end_a), 32'h1);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        chk("t3_stop_no_wait", 32'({in_wait_a, mem_wr_a}), 32'h0);
        tick(); tick();
        chk("t3_count", 32'(wa - w0), 32'd1);
        chk("t3_w0", 32'({la[w0], lda[w0]}), 32'h200055);
        finish_load();
        chk("t3_end_sticky", 32'(end_a), 32'h1);

        // backpressure during a run of 4
        begin_load(1'b1);
        wait_hold();
        w0 = wa;
        send(8'hED, 1'b0);
        send(8'h04, 1'b0);
        send(8'h5A, 1'b0);
        tick();
        mem_ready = 1'b0;
        frz = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(mem_wr_a && addr_a == 16'h2001 && data_a == 8'h5A && in_wait_a)) frz = 1'b0;
        end
        chk("t4_frozen", 32'(frz), 32'h1);
        mem_ready = 1'b1;
        n = 0;
        while (in_wait_a && n < 20) begin tick(); n++; end
        chk("t4_release", 32'(in_wait_a), 32'h0);
        chk("t4_count", 32'(wa - w0), 32'd4);
        chk("t4_first", 32'({la[w0], lda[w0]}), 32'h20005A);
        chk("t4_last", 32'({la[w0+3], lda[w0+3]}), 32'h20035A);
        finish_load();

        // overflow on the FFFE instance
        begin_load(1'b1);
        wait_hold();
        w0 = wb;
        send(8'hED, 1'b1);
        send(8'h04, 1'b1);
        send(8'hAA, 1'b1);
        n = 0;
        while (in_wait_b && n < 20) begin tick(); n++; end
        chk("t5_release", 32'(in_wait_b), 32'h0);
        chk("t5_count", 32'(wb - w0), 32'd2);
        chk("t5_w0", 32'({lb[w0], ldb[w0]}), 32'hFFFEAA);
        chk("t5_w1", 32'({lb[w0+1], ldb[w0+1]}), 32'hFFFFAA);
        chk("t5_ovf", 32'({ovf_b, mem_wr_b}), 32'h2);
        chk("t5_no_ovf_a", 32'(ovf_a), 32'h0);
        finish_load();
        chk("t5_ovf_sticky", 32'(ovf_b), 32'h1);

        // reset mid-run
        begin_load(1'b1);
        wait_hold();
        send(8'hED, 1'b0);
        send(8'h0A, 1'b0);
        send(8'h99, 1'b0);
        tick(); tick();
        chk("t6_at_w3", 32'({mem_wr_a, addr_a}), 32'({1'b1, 16'h2002}));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_outs", 32'({mem_wr_a, busy_a, in_wait_a, hold_a, end_a, ovf_a}), 32'h0);
        chk("t6_rst_addr", 32'(addr_a), 32'h2000);
        chk("t6_rst_ovf_b", 32'({ovf_b, addr_b}), 32'h0FFFE);
        begin_load(1'b0);
        wait_hold();
        w0 = wa;
        send(8'h12, 1'b0);
        tick(); tick();
        chk("t6_count", 32'(wa - w0), 32'd1);
        chk("t6_w0", 32'({la[w0], lda[w0]}), 32'h200012);
        finish_load();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
